// File: rtl/glip_fifo_bridge_if.sv
// Bundle of the host-side and logic-side signals of the GLIP FIFO bridge.
// The bridge itself uses the slave modport; the host/logic environment
// uses the master modport.
interface glip_fifo_bridge_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = 2 * AW + 8;

  // host side
  logic [WIDTH-1:0] host_wr_data;
  logic             host_wr_en;
  logic [WIDTH-1:0] host_rd_data;
  logic             host_rd_en;
  logic             host_ctrl_we;
  logic [2:0]       host_ctrl_wdata;
  logic [SW-1:0]    host_status;

  // logic side
  logic [WIDTH-1:0] fifo_in_data;
  logic             fifo_in_valid;
  logic             fifo_in_ready;
  logic [WIDTH-1:0] fifo_out_data;
  logic             fifo_out_valid;
  logic             fifo_out_ready;

  // control / status outputs
  logic             com_rst;
  logic             logic_rst;
  logic             error;

  modport master (
    output host_wr_data, host_wr_en, host_rd_en, host_ctrl_we, host_ctrl_wdata,
    output fifo_in_ready, fifo_out_data, fifo_out_valid,
    input  host_rd_data, host_status, fifo_in_data, fifo_in_valid,
    input  fifo_out_ready, com_rst, logic_rst, error
  );

  modport slave (
    input  host_wr_data, host_wr_en, host_rd_en, host_ctrl_we, host_ctrl_wdata,
    input  fifo_in_ready, fifo_out_data, fifo_out_valid,
    output host_rd_data, host_status, fifo_in_data, fifo_in_valid,
    output fifo_out_ready, com_rst, logic_rst, error
  );
endinterface

// File: rtl/glip_fifo_bridge.sv
// GLIP FIFO bridge: one first-word-fall-through FIFO per direction between
// a host port and user logic, plus a small control register (communication
// reset, logic reset, error clear) and sticky overflow/underflow flags.
module glip_fifo_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  glip_fifo_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Head words are read combinationally so the FIFOs fall through;
  // this maps to distributed RAM rather than block RAM.
  logic [WIDTH-1:0] in_mem  [DEPTH];
  logic [WIDTH-1:0] out_mem [DEPTH];

  logic [AW-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
  logic [AW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
  logic [LW-1:0] in_level_reg, out_level_reg;
  logic          in_ovf_reg, out_udf_reg;
  logic          com_rst_reg, logic_rst_reg;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic flush, err_clr;

  // Full/empty come from pre-edge levels, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  always_comb begin
    in_full   = (in_level_reg == LW'(DEPTH));
    in_empty  = (in_level_reg == '0);
    out_full  = (out_level_reg == LW'(DEPTH));
    out_empty = (out_level_reg == '0);
    in_push   = bus.host_wr_en && !in_full && !com_rst_reg;
    in_pop    = !in_empty && bus.fifo_in_ready;
    out_push  = bus.fifo_out_valid && !out_full && !com_rst_reg;
    out_pop   = bus.host_rd_en && !out_empty;
    // Flush on the same edge com_rst is loaded so the FIFOs read empty as
    // soon as com_rst is visible, and keep them empty while it stays set.
    flush     = com_rst_reg || (bus.host_ctrl_we && bus.host_ctrl_wdata[0]);
    err_clr   = bus.host_ctrl_we && bus.host_ctrl_wdata[2];
  end

  // Data storage; contents are not reset, only pointers and levels are.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr_reg]   <= bus.host_wr_data;
    if (out_push) out_mem[out_wr_ptr_reg] <= bus.fifo_out_data;
  end

  // In-FIFO pointers and level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_level_reg  <= '0;
    end else if (flush) begin
      in_wr_ptr_reg <= '0;
      in_rd_ptr_reg <= '0;
      in_level_reg  <= '0;
    end else begin
      if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
      if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
      in_level_reg <= in_level_reg + LW'(in_push) - LW'(in_pop);
    end
  end

  // Out-FIFO pointers and level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_level_reg  <= '0;
    end else if (flush) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_level_reg  <= '0;
    end else begin
      if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
      if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
      out_level_reg <= out_level_reg + LW'(out_push) - LW'(out_pop);
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ovf_reg  <= 1'b0;
      out_udf_reg <= 1'b0;
    end else begin
      in_ovf_reg  <= (in_ovf_reg && !err_clr) || (bus.host_wr_en && in_full);
      out_udf_reg <= (out_udf_reg && !err_clr) || (bus.host_rd_en && out_empty);
    end
  end

  // Control register: reset outputs are plain register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      com_rst_reg   <= 1'b0;
      logic_rst_reg <= 1'b0;
    end else if (bus.host_ctrl_we) begin
      com_rst_reg   <= bus.host_ctrl_wdata[0];
      logic_rst_reg <= bus.host_ctrl_wdata[1];
    end
  end

  assign bus.host_rd_data   = out_mem[out_rd_ptr_reg];
  assign bus.fifo_in_data   = in_mem[in_rd_ptr_reg];
  assign bus.fifo_in_valid  = !in_empty;
  assign bus.fifo_out_ready = !out_full && !com_rst_reg;
  assign bus.com_rst        = com_rst_reg;
  assign bus.logic_rst      = logic_rst_reg;
  assign bus.error          = in_ovf_reg | out_udf_reg;
  assign bus.host_status    = {in_ovf_reg, out_udf_reg, in_full, in_empty,
                               out_full, out_empty, in_level_reg, out_level_reg};
endmodule

// File: tb/tb_glip_fifo_bridge.sv
// Scoreboard bench for glip_fifo_bridge (WIDTH=16, DEPTH=16).
// Stimulus pushes expected words into queues; a monitor pops and compares
// whenever a word leaves either FIFO.
module tb_glip_fifo_bridge;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  glip_fifo_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  glip_fifo_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [WIDTH-1:0] in_exp  [$];
  logic [WIDTH-1:0] out_exp [$];

  // status field builder: {ovf, udf, in_full, in_empty, out_full, out_empty, in_lvl, out_lvl}
  function automatic logic [15:0] st(input logic ovf, input logic udf,
                                     input logic ifu, input logic iem,
                                     input logic ofu, input logic oem,
                                     input int ilv, input int olv);
    logic [4:0] il;
    logic [4:0] ol;
    il = 5'(ilv);
    ol = 5'(olv);
    return {ovf, udf, ifu, iem, ofu, oem, il, ol};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on the falling edge, a pop that will happen on the next rising
  // edge presents its head word, which must match the scoreboard.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.fifo_in_valid && bus.fifo_in_ready) begin
        if (in_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL in_pop: got 0x%0h expected no word", bus.fifo_in_data);
        end else begin
          e = in_exp.pop_front();
          chk("in_pop", 64'(bus.fifo_in_data), 64'(e));
        end
      end
      if (rst_n && bus.host_rd_en && !bus.host_status[10]) begin
        if (out_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_pop: got 0x%0h expected no word", bus.host_rd_data);
        end else begin
          e = out_exp.pop_front();
          chk("out_pop", 64'(bus.host_rd_data), 64'(e));
        end
      end
    end
  end

  initial begin
    int in_cnt, out_cnt, in_pu, in_po, out_pu, out_po, iter;
    logic [WIDTH-1:0] d;
    logic we, rd, ov, ir;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.host_wr_data = '0;
    bus.host_wr_en = 1'b0;
    bus.host_rd_en = 1'b0;
    bus.host_ctrl_we = 1'b0;
    bus.host_ctrl_wdata = 3'b000;
    bus.fifo_in_ready = 1'b0;
    bus.fifo_out_data = '0;
    bus.fifo_out_valid = 1'b0;

    // reset state
    repeat (2) cyc();
    chk("rst_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("rst_in_valid", 64'(bus.fifo_in_valid), 64'd0);
    chk("rst_out_ready", 64'(bus.fifo_out_ready), 64'd1);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_ctrl", 64'({bus.com_rst, bus.logic_rst}), 64'd0);
    rst_n = 1'b1;
    cyc();

    // fill the in-FIFO with 0x0001..0x0010
    for (int i = 1; i <= DEPTH; i++) begin
      bus.host_wr_en = 1'b1;
      bus.host_wr_data = WIDTH'(i);
      in_exp.push_back(WIDTH'(i));
      cyc();
    end
    bus.host_wr_en = 1'b0;
    chk("fill_status", 64'(bus.host_status), 64'(st(0,0,1,0,0,1,16,0)));
    chk("fill_head", 64'(bus.fifo_in_data), 64'h0001);
    chk("fill_error", 64'(bus.error), 64'd0);
    // 17th push overflows
    bus.host_wr_en = 1'b1;
    bus.host_wr_data = 16'h0011;
    cyc();
    bus.host_wr_en = 1'b0;
    chk("ovf_status", 64'(bus.host_status), 64'(st(1,0,1,0,0,1,16,0)));
    chk("ovf_error", 64'(bus.error), 64'd1);

    // push and pop on a full FIFO: pop happens, push dropped
    bus.host_wr_en = 1'b1;
    bus.host_wr_data = 16'h0022;
    bus.fifo_in_ready = 1'b1;
    cyc();
    bus.host_wr_en = 1'b0;
    chk("full_pushpop_status", 64'(bus.host_status), 64'(st(1,0,0,0,0,1,15,0)));
    chk("full_pushpop_head", 64'(bus.fifo_in_data), 64'h0002);
    repeat (DEPTH - 1) cyc();
    bus.fifo_in_ready = 1'b0;
    chk("drain_status", 64'(bus.host_status), 64'(st(1,0,0,1,0,1,0,0)));
    chk("drain_in_valid", 64'(bus.fifo_in_valid), 64'd0);

    // clear errors
    bus.host_ctrl_we = 1'b1;
    bus.host_ctrl_wdata = 3'b100;
    cyc();
    bus.host_ctrl_we = 1'b0;
    chk("clr_error", 64'(bus.error), 64'd0);
    chk("clr_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));

    // underflow, then clear with concurrent underflow
    bus.host_rd_en = 1'b1;
    cyc();
    bus.host_rd_en = 1'b0;
    chk("udf_status", 64'(bus.host_status), 64'(st(0,1,0,1,0,1,0,0)));
    chk("udf_error", 64'(bus.error), 64'd1);
    bus.host_rd_en = 1'b1;
    bus.host_ctrl_we = 1'b1;
    bus.host_ctrl_wdata = 3'b100;
    cyc();
    bus.host_rd_en = 1'b0;
    chk("clr_vs_udf", 64'(bus.host_status), 64'(st(0,1,0,1,0,1,0,0)));
    cyc();
    bus.host_ctrl_we = 1'b0;
    chk("clr2_error", 64'(bus.error), 64'd0);

    // logic-to-host words
    bus.fifo_out_valid = 1'b1;
    bus.fifo_out_data = 16'hA5A5;
    out_exp.push_back(16'hA5A5);
    cyc();
    bus.fifo_out_data = 16'h5A5A;
    out_exp.push_back(16'h5A5A);
    cyc();
    bus.fifo_out_valid = 1'b0;
    chk("out_lvl2", 64'(bus.host_status), 64'(st(0,0,0,1,0,0,0,2)));
    chk("out_head", 64'(bus.host_rd_data), 64'hA5A5);
    bus.host_rd_en = 1'b1;
    cyc();
    bus.host_rd_en = 1'b0;
    chk("out_lvl1", 64'(bus.host_status), 64'(st(0,0,0,1,0,0,0,1)));
    bus.host_rd_en = 1'b1;
    cyc();
    bus.host_rd_en = 1'b0;
    chk("out_lvl0", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));

    // communication reset flushes buffered words
    for (int i = 0; i < 5; i++) begin
      bus.fifo_out_valid = 1'b1;
      bus.fifo_out_data = WIDTH'(16'h0100 + i);
      cyc();
    end
    bus.fifo_out_valid = 1'b0;
    chk("out_lvl5", 64'(bus.host_status), 64'(st(0,0,0,1,0,0,0,5)));
    bus.host_ctrl_we = 1'b1;
    bus.host_ctrl_wdata = 3'b011;
    cyc();
    bus.host_ctrl_we = 1'b0;
    chk("comrst_ctrl", 64'({bus.com_rst, bus.logic_rst}), 64'b11);
    chk("comrst_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("comrst_ready", 64'(bus.fifo_out_ready), 64'd0);
    bus.host_wr_en = 1'b1;
    bus.host_wr_data = 16'hDEAD;
    bus.fifo_out_valid = 1'b1;
    bus.fifo_out_data = 16'hBEEF;
    cyc();
    bus.host_wr_en = 1'b0;
    bus.fifo_out_valid = 1'b0;
    chk("comrst_push_ignored", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("comrst_in_valid", 64'(bus.fifo_in_valid), 64'd0);
    bus.host_ctrl_we = 1'b1;
    bus.host_ctrl_wdata = 3'b000;
    cyc();
    bus.host_ctrl_we = 1'b0;
    chk("comrst_release_ready", 64'(bus.fifo_out_ready), 64'd1);
    chk("comrst_release_ctrl", 64'({bus.com_rst, bus.logic_rst}), 64'b00);

    // pointer wrap: 3*DEPTH words each way with random interleaving
    in_cnt = 0; out_cnt = 0; in_pu = 0; in_po = 0; out_pu = 0; out_po = 0; iter = 0;
    while ((in_po < 3 * DEPTH || out_po < 3 * DEPTH) && iter < 4000) begin
      we = (in_pu < 3 * DEPTH) && (in_cnt < DEPTH) && ($urandom_range(0, 1) == 1);
      ir = (in_cnt > 0) && ($urandom_range(0, 1) == 1);
      ov = (out_pu < 3 * DEPTH) && (out_cnt < DEPTH) && ($urandom_range(0, 1) == 1);
      rd = (out_cnt > 0) && ($urandom_range(0, 1) == 1);
      bus.host_wr_en = we;
      bus.fifo_in_ready = ir;
      bus.fifo_out_valid = ov;
      bus.host_rd_en = rd;
      if (we) begin
        d = WIDTH'($urandom);
        bus.host_wr_data = d;
        in_exp.push_back(d);
      end
      if (ov) begin
        d = WIDTH'($urandom);
        bus.fifo_out_data = d;
        out_exp.push_back(d);
      end
      cyc();
      in_cnt  = in_cnt + int'(we) - int'(ir);
      out_cnt = out_cnt + int'(ov) - int'(rd);
      in_pu  += int'(we);
      in_po  += int'(ir);
      out_pu += int'(ov);
      out_po += int'(rd);
      iter++;
    end
    bus.host_wr_en = 1'b0;
    bus.fifo_in_ready = 1'b0;
    bus.fifo_out_valid = 1'b0;
    bus.host_rd_en = 1'b0;
    chk("wrap_done_in_time", 64'(iter < 4000), 64'd1);
    chk("wrap_error", 64'(bus.error), 64'd0);
    chk("wrap_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("wrap_in_sb_empty", 64'(in_exp.size()), 64'd0);
    chk("wrap_out_sb_empty", 64'(out_exp.size()), 64'd0);

    // asynchronous reset in the middle of a transfer
    for (int i = 0; i < 3; i++) begin
      bus.host_wr_en = 1'b1;
      bus.host_wr_data = WIDTH'(16'h0300 + i);
      bus.fifo_out_valid = 1'b1;
      bus.fifo_out_data = WIDTH'(16'h0400 + i);
      cyc();
    end
    chk("pre_rst_status", 64'(bus.host_status), 64'(st(0,0,0,0,0,0,3,3)));
    rst_n = 1'b0;
    #1;
    chk("async_rst_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("async_rst_in_valid", 64'(bus.fifo_in_valid), 64'd0);
    bus.host_wr_en = 1'b0;
    bus.fifo_out_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_status", 64'(bus.host_status), 64'(st(0,0,0,1,0,1,0,0)));
    chk("post_rst_in_valid", 64'(bus.fifo_in_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/glip_fifo_bridge.md
GLIP_FIFO_BRIDGE -- requirements
Module: glip_fifo_bridge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the data word width (8..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, setting the per-direction FIFO depth (power of two, >=2); AW = log2(DEPTH).
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- host_wr_data  in  WIDTH  host word to push into the in-FIFO.
- host_wr_en  in  1  push request.
- host_rd_data  out  WIDTH  head of the out-FIFO.
- host_rd_en  in  1  pop request.
- host_ctrl_we  in  1  control-register write strobe.
- host_ctrl_wdata  in  3  bit0 com_rst, bit1 logic_rst, bit2 clear-errors.
- host_status  out  2*AW+8  {in_ovf, out_udf, in_full, in_empty, out_full, out_empty, in_level[AW:0], out_level[AW:0]}.
- fifo_in_data  out  WIDTH  in-FIFO head to logic.
- fifo_in_valid  out  1  in-FIFO non-empty.
- fifo_in_ready  in  1  logic consumes head.
- fifo_out_data  in  WIDTH  logic word to out-FIFO.
- fifo_out_valid  in  1  logic offers word.
- fifo_out_ready  out  1  out-FIFO not full.
- com_rst  out  1  communication reset.
- logic_rst  out  1  logic reset.
- error  out  1  OR of sticky error flags.

Function
REQ-004 Both FIFOs SHALL be first-word-fall-through: head data visible combinationally when the level is non-zero.
REQ-005 In-FIFO push SHALL occur on a clk edge with host_wr_en=1 and in_level<DEPTH; pop on fifo_in_valid & fifo_in_ready.
REQ-006 Out-FIFO push SHALL occur on fifo_out_valid & fifo_out_ready; pop on host_rd_en=1 and out_level>0.
REQ-007 Full/empty SHALL be evaluated on pre-edge levels: a push to a full FIFO is dropped even if a pop occurs the same cycle; simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
REQ-008 Levels SHALL be AW+1 bits (0..DEPTH); read/write pointers AW bits, wrapping DEPTH-1 -> 0.
REQ-009 fifo_in_valid SHALL equal (in_level!=0); fifo_out_ready SHALL equal (out_level!=DEPTH) and not com_rst.
REQ-010 in_ovf SHALL set on host_wr_en=1 with in FIFO full; out_udf SHALL set on host_rd_en=1 with out FIFO empty; both sticky.
REQ-011 host_ctrl_we with wdata bit2=1 SHALL clear both sticky flags next edge; a new error event the same cycle SHALL win (flag stays set).
REQ-012 host_ctrl_we SHALL load com_rst and logic_rst from wdata bits 0/1 next edge; outputs are the register values (1-cycle latency).
REQ-013 While com_rst=1, both FIFOs SHALL be held empty (pointers, levels 0), all pushes ignored; sticky flags unaffected.
REQ-014 error SHALL equal in_ovf | out_udf, registered-source, no combinational path from inputs.
REQ-015 Status fields SHALL reflect post-edge register state (no look-ahead).

Reset
REQ-016 rst_n=0 SHALL asynchronously clear pointers, levels, sticky flags, com_rst, logic_rst; outputs then: fifo_in_valid=0, fifo_out_ready=1, error=0, host_status empty bits=1, others 0.
REQ-017 Deassertion of rst_n SHALL take effect on the next clk edge; FIFO memory contents need not be reset.
REQ-018 rst_n asserted mid-transfer SHALL discard all buffered words; no partial word is delivered after release.

Verification
REQ-019 Push 0x0001..0x0010 via host_wr_en (DEPTH=16), fifo_in_ready=0 -> in_level=16, in_full=1, fifo_in_data=0x0001; 17th push -> in_ovf=1, error=1, level stays 16.
REQ-020 In FIFO full, host_wr_en and fifo_in_ready both 1 one cycle -> pop occurs, push dropped, in_level=15, in_ovf=1.
REQ-021 host_rd_en with out FIFO empty -> out_udf=1; ctrl write 3'b100 -> error=0 next cycle; ctrl write 3'b100 with concurrent underflow -> out_udf remains 1.
REQ-022 Logic pushes 0xA5A5,0x5A5A; host pops twice -> host_rd_data 0xA5A5 then 0x5A5A, out_level 2->1->0, out_empty=1.
REQ-023 Out FIFO holding 5 words, ctrl write 3'b011 -> next cycle com_rst=1, logic_rst=1, out_level=0, fifo_out_ready=0; ctrl write 3'b000 -> ready=1 next cycle.
REQ-024 Pointer wrap: 3*DEPTH push/pop pairs with random interleaving -> data order matches scoreboard, no ovf/udf.
